// File: rtl/cacheline_mem_responder_pkg.sv
// Shared constants, FSM state type and address alignment helper for the
// cacheline responder.
package cacheline_mem_responder_pkg;
  localparam int ADDR_BITS = 32;
  localparam int CL_BITS   = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = CL_BITS / BEAT_BITS;
  localparam int CNT_W     = $clog2(BEATS);
  localparam int OFS_BITS  = $clog2(CL_BITS / 8);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} cl_resp_state_t;

  function automatic logic [ADDR_BITS-1:0] align_addr(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:OFS_BITS], {OFS_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_mem_responder_if.sv
// Cacheline request side plus banked burst-memory side of the responder.
// master = dcache/memory environment, slave = the responder itself.
interface cacheline_mem_responder_if;
  import cacheline_mem_responder_pkg::*;

  logic [ADDR_BITS-1:0] cl_addr;
  logic                 cl_read;
  logic                 cl_write;
  logic [CL_BITS-1:0]   cl_wdata;
  logic [CL_BITS-1:0]   cl_rdata;
  logic                 cl_resp;

  logic [ADDR_BITS-1:0] bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [ADDR_BITS-1:0] bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  modport master (
    output cl_addr, cl_read, cl_write, cl_wdata,
    input  cl_rdata, cl_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  cl_addr, cl_read, cl_write, cl_wdata,
    output cl_rdata, cl_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_mem_responder_cl_beat_shifter.sv
// Line buffer and beat counter: whole-line load, per-beat insert at the
// counter position, and beat extract at an arbitrary index.
module cacheline_mem_responder_cl_beat_shifter
  import cacheline_mem_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [CL_BITS-1:0]   line_i,
  input  logic                 ins_vld_i,
  input  logic [BEAT_BITS-1:0] ins_beat_i,
  input  logic                 cnt_clr_i,
  input  logic                 cnt_inc_i,
  input  logic [CNT_W-1:0]     ext_idx_i,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [CL_BITS-1:0]   line_o,
  output logic [BEAT_BITS-1:0] ext_beat_o
);
  // Beat 0 occupies the low 64 bits of the flat line.
  logic [BEATS-1:0][BEAT_BITS-1:0] line_q;
  logic [CNT_W-1:0]                cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_i)
        line_q <= line_i;
      else if (ins_vld_i)
        line_q[cnt_q] <= ins_beat_i;
      if (cnt_clr_i)
        cnt_q <= '0;
      else if (cnt_inc_i)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o      = cnt_q;
  assign line_o     = line_q;
  assign ext_beat_o = line_q[ext_idx_i];
endmodule

// File: rtl/cacheline_mem_responder.sv
// Cacheline responder: splits one 256-bit line read/write into 64-bit bursts.
// Optional sticky protocol error output when CL_RESP_ERR_EN is defined.
module cacheline_mem_responder
  import cacheline_mem_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cacheline_mem_responder_if.slave bus
`ifdef CL_RESP_ERR_EN
  ,
  output logic err
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  cl_resp_state_t       state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BEAT_BITS-1:0] wdata_q, wdata_d;
  logic                 rd_q, rd_d, wr_q, wr_d, resp_q, resp_d;

  logic                 load, ins_vld, cnt_clr, cnt_inc;
  logic [CNT_W-1:0]     cnt, ext_idx;
  logic [CL_BITS-1:0]   line;
  logic [BEAT_BITS-1:0] ext_beat;

  cacheline_mem_responder_cl_beat_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .line_i     (bus.cl_wdata),
    .ins_vld_i  (ins_vld),
    .ins_beat_i (bus.bmem_rdata),
    .cnt_clr_i  (cnt_clr),
    .cnt_inc_i  (cnt_inc),
    .ext_idx_i  (ext_idx),
    .cnt_o      (cnt),
    .line_o     (line),
    .ext_beat_o (ext_beat)
  );

  // Write beats are pre-fetched one ahead so bmem_wdata stays registered.
  assign ext_idx = cnt + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    resp_d  = 1'b0;
    load    = 1'b0;
    ins_vld = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cl_write) begin
          state_d = WR_DATA;
          addr_d  = align_addr(bus.cl_addr);
          wdata_d = bus.cl_wdata[BEAT_BITS-1:0];
          wr_d    = 1'b1;
          load    = 1'b1;
          cnt_clr = 1'b1;
        end else if (bus.cl_read) begin
          state_d = RD_CMD;
          addr_d  = align_addr(bus.cl_addr);
          rd_d    = 1'b1;
        end
      end
      RD_CMD: begin
        if (bus.bmem_ready) begin
          state_d = RD_DATA;
          cnt_clr = 1'b1;
        end else begin
          rd_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (bus.bmem_rvalid) begin
          ins_vld = 1'b1;
          cnt_inc = 1'b1;
          if (cnt == LAST) begin
            state_d = RESP;
            resp_d  = 1'b1;
          end
        end
      end
      WR_DATA: begin
        wr_d = 1'b1;
        if (bus.bmem_ready) begin
          cnt_inc = 1'b1;
          if (cnt == LAST) begin
            state_d = RESP;
            wr_d    = 1'b0;
            resp_d  = 1'b1;
          end else begin
            wdata_d = ext_beat;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_read  = rd_q;
  assign bus.bmem_write = wr_q;
  assign bus.bmem_wdata = wdata_q;
  assign bus.cl_resp    = resp_q;
  assign bus.cl_rdata   = line;

`ifdef CL_RESP_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.bmem_rvalid && ((state_q != RD_DATA) || (bus.bmem_raddr != addr_q)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_cacheline_mem_responder.sv
// Directed bench for cacheline_mem_responder; inputs change 1 time unit after
// posedge and outputs are checked there, cycle counts are taken on negedge.
module tb_cacheline_mem_responder;
  import cacheline_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   resp_cnt = 0, rd_cnt = 0, c_hold = 0;
  int   base_resp, base_rd;

  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;

  cacheline_mem_responder_if bus ();
`ifdef CL_RESP_ERR_EN
  logic err;
`endif

  cacheline_mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CL_RESP_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cl_resp) resp_cnt++;
    if (bus.bmem_read) rd_cnt++;
    if (bus.bmem_write && bus.bmem_wdata == BC) c_hold++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] beats [4];
    bus.cl_addr = '0; bus.cl_read = 0; bus.cl_write = 0; bus.cl_wdata = '0;
    bus.bmem_ready = 1; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 0;

    // Reset state
    step(); step();
    chk("rst_resp", 256'(bus.cl_resp), 256'd0);
    chk("rst_read", 256'(bus.bmem_read), 256'd0);
    chk("rst_write", 256'(bus.bmem_write), 256'd0);
    chk("rst_addr", 256'(bus.bmem_addr), 256'd0);
    chk("rst_rdata", bus.cl_rdata, 256'd0);
    rst = 0;
    step();

    // Read, zero wait, memory answers 2 cycles after command
    base_resp = resp_cnt; base_rd = rd_cnt;
    bus.cl_read = 1; bus.cl_addr = 32'h0000_1234; bus.bmem_raddr = 32'h0000_1220;
    step();
    chk("rd1_cmd", 256'(bus.bmem_read), 256'd1);
    chk("rd1_addr", 256'(bus.bmem_addr), 256'h1220);
    step();
    chk("rd1_cmd_drop", 256'(bus.bmem_read), 256'd0);
    step();
    bus.bmem_rvalid = 1;
    bus.bmem_rdata = 64'h1111_1111_1111_1111; step();
    bus.bmem_rdata = 64'h2222_2222_2222_2222; step();
    bus.bmem_rdata = 64'h3333_3333_3333_3333; step();
    chk("rd1_noresp_early", 256'(bus.cl_resp), 256'd0);
    bus.bmem_rdata = 64'h4444_4444_4444_4444; step();
    bus.bmem_rvalid = 0;
    chk("rd1_resp", 256'(bus.cl_resp), 256'd1);
    chk("rd1_data", bus.cl_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    bus.cl_read = 0;
    step();
    chk("rd1_resp_pulse", 256'(bus.cl_resp), 256'd0);
    step();
    chk("rd1_resp_cnt", 256'(resp_cnt - base_resp), 256'd1);
    chk("rd1_cmd_cnt", 256'(rd_cnt - base_rd), 256'd1);

    // Write with backpressure on beat 2 for 3 cycles
    base_resp = resp_cnt;
    bus.cl_write = 1; bus.cl_addr = 32'h8000_0040; bus.cl_wdata = {BD, BC, BB, BA};
    step();
    chk("wr_valid", 256'(bus.bmem_write), 256'd1);
    chk("wr_addr", 256'(bus.bmem_addr), 256'h8000_0040);
    chk("wr_beatA", 256'(bus.bmem_wdata), 256'(BA));
    step();
    chk("wr_beatB", 256'(bus.bmem_wdata), 256'(BB));
    step();
    chk("wr_beatC", 256'(bus.bmem_wdata), 256'(BC));
    bus.bmem_ready = 0;
    step();
    chk("wr_holdC1", 256'(bus.bmem_wdata), 256'(BC));
    step();
    chk("wr_holdC2", 256'(bus.bmem_wdata), 256'(BC));
    step();
    chk("wr_holdC3", 256'({bus.bmem_write, bus.bmem_wdata}), 256'({1'b1, BC}));
    bus.bmem_ready = 1;
    step();
    chk("wr_beatD", 256'(bus.bmem_wdata), 256'(BD));
    chk("wr_noresp_early", 256'(bus.cl_resp), 256'd0);
    step();
    chk("wr_resp", 256'(bus.cl_resp), 256'd1);
    chk("wr_write_drop", 256'(bus.bmem_write), 256'd0);
    bus.cl_write = 0;
    step();
    chk("wr_resp_pulse", 256'(bus.cl_resp), 256'd0);
    step();
    chk("wr_c_hold_cycles", 256'(c_hold), 256'd4);
    chk("wr_resp_cnt", 256'(resp_cnt - base_resp), 256'd1);

    // Read with 1-cycle gaps between beats
    base_resp = resp_cnt;
    beats[0] = 64'h5555_5555_5555_5555; beats[1] = 64'h6666_6666_6666_6666;
    beats[2] = 64'h7777_7777_7777_7777; beats[3] = 64'h8888_8888_8888_8888;
    bus.cl_read = 1; bus.cl_addr = 32'h0000_011F; bus.bmem_raddr = 32'h0000_0100;
    step();
    chk("rd2_addr", 256'(bus.bmem_addr), 256'h100);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = 1; bus.bmem_rdata = beats[i];
      step();
      bus.bmem_rvalid = 0;
      if (i < 3) begin
        chk("rd2_noresp_gap", 256'(bus.cl_resp), 256'd0);
        step();
      end
    end
    chk("rd2_resp", 256'(bus.cl_resp), 256'd1);
    chk("rd2_data", bus.cl_rdata, {beats[3], beats[2], beats[1], beats[0]});
    bus.cl_read = 0;
    step(); step();
    chk("rd2_resp_cnt", 256'(resp_cnt - base_resp), 256'd1);

    // Simultaneous read and write: write wins, no read command
    base_resp = resp_cnt; base_rd = rd_cnt;
    bus.cl_read = 1; bus.cl_write = 1; bus.cl_addr = 32'h0000_0040;
    bus.cl_wdata = {4{64'h1234_5678_9ABC_DEF0}};
    step();
    chk("both_write", 256'({bus.bmem_write, bus.bmem_read}), 256'b10);
    chk("both_beat0", 256'(bus.bmem_wdata), 256'h1234_5678_9ABC_DEF0);
    step(); step(); step();
    chk("both_noresp_early", 256'(bus.cl_resp), 256'd0);
    step();
    chk("both_resp", 256'(bus.cl_resp), 256'd1);
    bus.cl_read = 0; bus.cl_write = 0;
    step(); step();
    chk("both_no_rdcmd", 256'(rd_cnt - base_rd), 256'd0);
    chk("both_resp_cnt", 256'(resp_cnt - base_resp), 256'd1);

    // Reset after beat 1 of a read, then stale beats
    base_resp = resp_cnt;
    bus.cl_read = 1; bus.cl_addr = 32'h0000_0200; bus.bmem_raddr = 32'h0000_0200;
    step(); step();
    bus.bmem_rvalid = 1; bus.bmem_rdata = 64'hDEAD_0000_0000_0000; step();
    bus.bmem_rdata = 64'hDEAD_1111_1111_1111; step();
    bus.bmem_rvalid = 0; bus.cl_read = 0; rst = 1;
    step();
    rst = 0;
    chk("mid_rst_rdata", bus.cl_rdata, 256'd0);
    chk("mid_rst_idle", 256'({bus.bmem_read, bus.bmem_write, bus.cl_resp}), 256'd0);
    bus.bmem_rvalid = 1; bus.bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; step();
    bus.bmem_rdata = 64'hBAD1_BAD1_BAD1_BAD1; step();
    bus.bmem_rvalid = 0;
    step();
    chk("mid_rst_stale", 256'({resp_cnt - base_resp, 28'(0), bus.bmem_read}), 256'd0);
    bus.cl_read = 1; bus.cl_addr = 32'h0000_0300; bus.bmem_raddr = 32'h0000_0300;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = 1; bus.bmem_rdata = {8{8'(i + 1)}};
      step();
    end
    bus.bmem_rvalid = 0;
    chk("rd3_resp", 256'(bus.cl_resp), 256'd1);
    chk("rd3_clean_data", bus.cl_rdata, {{8{8'h04}}, {8{8'h03}}, {8{8'h02}}, {8{8'h01}}});
    bus.cl_read = 0;
    step(); step();

`ifdef CL_RESP_ERR_EN
    rst = 1; step(); rst = 0;
    chk("err_clear", 256'(err), 256'd0);
    bus.bmem_rvalid = 1; step(); bus.bmem_rvalid = 0;
    chk("err_set", 256'(err), 256'd1);
    step(); step();
    chk("err_sticky", 256'(err), 256'd1);
    rst = 1; step(); rst = 0;
    chk("err_rst", 256'(err), 256'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cacheline_mem_responder.md
Name: cacheline_mem_responder

Overview:
- Slave (responder) end of the cacheline interface. The backend LSU/dcache path drives it as master.
- Each 256-bit cacheline read or write becomes a sequence of 64-bit bursts on the banked memory port.
- Sits between the dcache and the memory arbiter.
- Serves one request at a time; a response is signalled by a one-cycle resp pulse.

Parameters:
- ADDR_BITS, 32, byte address width.
- CL_BITS, 256, cacheline width.
- BEAT_BITS, 64, memory burst beat width.
- BEATS, CL_BITS/BEAT_BITS (4), beats per line. Derived parameter, not to be overridden.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- cl_addr  in  ADDR_BITS  request byte address; low 5 bits ignored.
- cl_read  in  1  read request, held until cl_resp.
- cl_write  in  1  write request, held until cl_resp.
- cl_wdata  in  CL_BITS  write line, held until cl_resp.
- cl_rdata  out  CL_BITS  read line, valid when cl_resp is high.
- cl_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  ADDR_BITS  32B-aligned burst address.
- bmem_read  out  1  one-cycle read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_BITS  write beat.
- bmem_ready  in  1  memory accepts a command or beat this cycle.
- bmem_raddr  in  ADDR_BITS  address tag of the returning beat.
- bmem_rdata  in  BEAT_BITS  read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Synchronous active-high reset:
  - State returns to IDLE; beat counter cleared; line buffer cleared.
  - All outputs 0.
  - Reset mid-transaction aborts it; late bmem_rvalid beats after reset are ignored in IDLE.
- Clock: everything on clk. Command outputs (bmem_*) and cl_resp are registered.
- FSM states IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - cl_write -> WR_DATA, latching the aligned address (cl_addr[31:5],5'b0), wdata and counter=0.
  - Else cl_read -> RD_CMD, latching the aligned address.
  - Write wins if both are asserted; asserting both is a protocol violation, and the read is not queued.
- RD_CMD:
  - Drive bmem_read=1 with bmem_addr.
  - When bmem_ready=1, the command is accepted: go to RD_DATA, counter=0.
  - Otherwise hold the command.
- RD_DATA:
  - Each bmem_rvalid stores bmem_rdata into line slice [counter*64 +: 64], then counter++.
  - Beat order: beat 0 = bits 63:0.
  - Beats may be non-consecutive.
  - After beat BEATS-1 -> RESP.
- WR_DATA:
  - Drive bmem_write=1, bmem_addr, bmem_wdata = wdata slice [counter*64 +: 64].
  - A beat advances only when bmem_ready=1; the same beat is re-driven while ready=0.
  - After beat BEATS-1 is accepted -> RESP.
- RESP:
  - cl_resp=1 for exactly one cycle, with cl_rdata valid (reads) or don't-care/last line (writes).
  - Next state IDLE.
  - The master must deassert its request in the cycle after cl_resp. A request still asserted in IDLE is a new request.
- Latency, zero memory wait:
  - Read: 1 cmd cycle + memory latency + 4 beats + 1 resp.
  - Write: request accepted in cycle N; beats N+1..N+4; cl_resp at N+5.
- Counter is log2(BEATS) wide; wrap to 0 is unused (the FSM exits first).
- bmem_rvalid outside RD_DATA is ignored.

Optional Feature:
- Macro CL_RESP_ERR_EN. When defined, adds output port err (1 bit, sticky until rst).
- err sets on either of:
  - bmem_rvalid outside RD_DATA.
  - bmem_raddr != latched aligned address during RD_DATA.
- When not defined:
  - No err port.
  - Stray beats are silently dropped.
  - bmem_raddr is unused.

Decomposition:
- Shared package cpu_params gains:
  - CL_BITS, BEAT_BITS, BEATS constants.
  - Enum cl_resp_state_t {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP}.
- One natural sub-module: cl_beat_shifter. It holds the line buffer and beat counter, and performs slice insert/extract. The FSM stays in the top module.

Test Plan:
- Read, zero wait:
  - Stimulus: cl_read at addr 0x0000_1234; memory answers 2 cycles after the cmd with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: bmem_read one cycle with bmem_addr=0x0000_1220; cl_rdata={44..,33..,22..,11..}; cl_resp exactly 1 cycle.
- Write with backpressure:
  - Stimulus: cl_write addr 0x8000_0040, wdata=256'h{D,C,B,A}; bmem_ready low on beat 2 for 3 cycles.
  - Response: beats A,B,C,D in order; beat C held stable for 4 cycles; cl_resp one cycle after beat D is accepted.
- Read with gapped rvalid:
  - Stimulus: beats arrive with 1-cycle gaps.
  - Response: correct assembly; cl_resp only after the 4th beat.
- Simultaneous read and write in IDLE:
  - Response: write executes, no bmem_read issued, a single cl_resp.
- Reset mid-read:
  - Stimulus: rst asserted after beat 1; 2 stale rvalid beats arrive afterwards.
  - Response: IDLE, no cl_resp; the next read returns clean data.
- With CL_RESP_ERR_EN:
  - Stimulus: rvalid while in IDLE.
  - Response: err=1 and stays high until rst.
